// File: rtl/kyber_ct_loader_if.sv
// rtl/kyber_ct_loader_if.sv - ciphertext word stream and core start towards the decapsulation core
interface kyber_ct_loader_if #(
  parameter int pWORD_WIDTH = 32
);
  logic [pWORD_WIDTH-1:0] word_o;
  logic                   word_valid_o;
  logic                   word_ready_i;
  logic                   word_last_o;
  logic                   core_start_o;

  modport master (
    output word_o,
    output word_valid_o,
    output word_last_o,
    output core_start_o,
    input  word_ready_i
  );

  modport slave (
    input  word_o,
    input  word_valid_o,
    input  word_last_o,
    input  core_start_o,
    output word_ready_i
  );
endinterface

// File: rtl/kyber_ct_loader.sv
// rtl/kyber_ct_loader.sv - collects host chunks, streams ciphertext words, pulses core start
// Optional running XOR checksum of drained words: define KYBER_CT_CHECKSUM_EN.
module kyber_ct_loader #(
  parameter int pCHUNK_WIDTH = 128,
  parameter int pNUM_CHUNKS  = 48,
  parameter int pWORD_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               load_i,
  input  logic [pCHUNK_WIDTH-1:0]            chunk_i,
  input  logic                               clear_i,
  kyber_ct_loader_if.master                  ct,
  output logic                               busy_o,
  output logic [$clog2(pNUM_CHUNKS+1)-1:0]   chunk_cnt_o,
  output logic                               overrun_o,
  output logic [pWORD_WIDTH-1:0]             checksum_o
);

  localparam int WPC = pCHUNK_WIDTH / pWORD_WIDTH;
  localparam int W   = pNUM_CHUNKS * WPC;
  localparam int CW  = $clog2(pNUM_CHUNKS + 1);
  localparam int WIW = (W > 1) ? $clog2(W) : 1;
  localparam int IW  = (pNUM_CHUNKS > 1) ? $clog2(pNUM_CHUNKS) : 1;
  localparam int SW  = (WPC > 1) ? $clog2(WPC) : 1;

  typedef enum logic [1:0] {S_FILL, S_DRAIN, S_KICK} state_t;

  state_t state, state_nxt;

  logic [WPC-1:0][pWORD_WIDTH-1:0] buffer [pNUM_CHUNKS];

  logic [CW-1:0]          chunk_cnt;
  logic [WIW-1:0]         w;
  logic [IW-1:0]          rd_chunk, nxt_chunk;
  logic [SW-1:0]          rd_sub, nxt_sub;
  logic [pWORD_WIDTH-1:0] word_q, first_word;
  logic                   overrun;
  logic                   accept, last_accept, fill_done;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    ct.word_valid_o = (state == S_DRAIN);
    ct.word_last_o  = (state == S_DRAIN) && (w == WIW'(W - 1));
    ct.core_start_o = (state == S_KICK);
    busy_o          = (state == S_DRAIN) || (state == S_KICK);
    accept          = (state == S_DRAIN) && ct.word_ready_i;
    last_accept     = accept && (w == WIW'(W - 1));
    fill_done       = (state == S_FILL) && load_i && (chunk_cnt == CW'(pNUM_CHUNKS - 1));
    if (clear_i) begin
      state_nxt = S_FILL;
    end else begin
      case (state)
        S_FILL:  if (fill_done) state_nxt = S_DRAIN;
        S_DRAIN: if (last_accept) state_nxt = S_KICK;
        S_KICK:  state_nxt = S_FILL;
        default: state_nxt = S_FILL;
      endcase
    end
  end

  // Read pointer of the word after the one currently presented.
  always_comb begin
    nxt_sub   = rd_sub + SW'(1);
    nxt_chunk = rd_chunk;
    if (rd_sub == SW'(WPC - 1)) begin
      nxt_sub   = '0;
      nxt_chunk = rd_chunk + IW'(1);
    end
  end

  // A single-chunk ciphertext has its word 0 still on chunk_i when DRAIN begins.
  assign first_word = (pNUM_CHUNKS == 1) ? chunk_i[pWORD_WIDTH-1:0] : buffer[0][0];

  always_ff @(posedge clk) begin
    if (resetn && !clear_i && state == S_FILL && load_i)
      buffer[chunk_cnt[IW-1:0]] <= chunk_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      chunk_cnt <= '0;
      w         <= '0;
      rd_chunk  <= '0;
      rd_sub    <= '0;
      overrun   <= 1'b0;
      word_q    <= '0;
    end else if (clear_i) begin
      chunk_cnt <= '0;
      w         <= '0;
      rd_chunk  <= '0;
      rd_sub    <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (load_i) begin
            chunk_cnt <= chunk_cnt + CW'(1);
            if (fill_done) begin
              word_q   <= first_word;
              w        <= '0;
              rd_chunk <= '0;
              rd_sub   <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (load_i) overrun <= 1'b1;
          if (accept && !last_accept) begin
            w        <= w + WIW'(1);
            rd_chunk <= nxt_chunk;
            rd_sub   <= nxt_sub;
            word_q   <= buffer[nxt_chunk][nxt_sub];
          end
        end
        S_KICK: begin
          if (load_i) overrun <= 1'b1;
          chunk_cnt <= '0;
          w         <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ct.word_o   = word_q;
  assign chunk_cnt_o = chunk_cnt;
  assign overrun_o   = overrun;

`ifdef KYBER_CT_CHECKSUM_EN
  logic [pWORD_WIDTH-1:0] checksum;

  always_ff @(posedge clk) begin
    if (!resetn || clear_i) checksum <= '0;
    else if (fill_done)     checksum <= '0;
    else if (accept)        checksum <= checksum ^ word_q;
  end

  assign checksum_o = checksum;
`else
  assign checksum_o = '0;
`endif

endmodule
